// File: rtl/md_sequencer_if.sv
// Handshake and result bundle between the E-stage pipeline and the mult/div sequencer.
interface md_sequencer_if;
  logic        start;
  logic [2:0]  MDop;
  logic [31:0] A;
  logic [31:0] B;
  logic        useMD;
  logic        req;
  logic        busy;
  logic        stall;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output start, MDop, A, B, useMD, req,
    input  busy, stall, HI, LO
  );

  modport slave (
    input  start, MDop, A, B, useMD, req,
    output busy, stall, HI, LO
  );
endinterface

// File: rtl/md_sequencer.sv
// Multi-cycle HI/LO sequencer: the result is computed at issue, held as pending,
// and committed to HI/LO when the busy down-counter reaches its terminal count.
//
// state | meaning
// IDLE  | no operation in flight; mthi/mtlo and new issues accepted
// MUL   | mult/multu in flight, cnt counting down MULT_CYCLES
// DIV   | div/divu in flight, cnt counting down DIV_CYCLES
module md_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic            clk,
  input  logic            reset,
  md_sequencer_if.slave   md
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = ($clog2(MAXC + 1) > 4) ? $clog2(MAXC + 1) : 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [31:0]    pend_hi, pend_lo;
  logic           pend_vld;
  logic [31:0]    hi_q, lo_q;

  logic           busy, go_mul, go_div, wr_hi, wr_lo, done;

  // Arithmetic: one shared multiplier and divider, sign handled around unsigned cores
  logic           op_signed;
  logic [63:0]    mul_a, mul_b, prod;
  logic [31:0]    mag_a, mag_b, div_b, q_u, r_u, quot, rem;

  always_comb begin
    op_signed = ~md.MDop[0];
    mul_a     = {{32{op_signed & md.A[31]}}, md.A};
    mul_b     = {{32{op_signed & md.B[31]}}, md.B};
    prod      = mul_a * mul_b;

    mag_a = (op_signed && md.A[31]) ? (~md.A + 32'd1) : md.A;
    mag_b = (op_signed && md.B[31]) ? (~md.B + 32'd1) : md.B;
    div_b = (mag_b == 32'd0) ? 32'd1 : mag_b;
    q_u   = mag_a / div_b;
    r_u   = mag_a % div_b;
    quot  = (op_signed && (md.A[31] ^ md.B[31])) ? (~q_u + 32'd1) : q_u;
    rem   = (op_signed && md.A[31]) ? (~r_u + 32'd1) : r_u;
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (go_mul)      state_nxt = MUL;
        else if (go_div) state_nxt = DIV;
      end
      MUL, DIV: begin
        if (done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != IDLE);
    go_mul = (state == IDLE) && md.start && !md.req &&
             ((md.MDop == 3'd0) || (md.MDop == 3'd1));
    go_div = (state == IDLE) && md.start && !md.req &&
             ((md.MDop == 3'd2) || (md.MDop == 3'd3));
    wr_hi  = (state == IDLE) && !md.req && (md.MDop == 3'd4);
    wr_lo  = (state == IDLE) && !md.req && (md.MDop == 3'd5);
    done   = busy && (cnt == CW'(1));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt      <= '0;
      pend_hi  <= '0;
      pend_lo  <= '0;
      pend_vld <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      if (go_mul) begin
        pend_hi  <= prod[63:32];
        pend_lo  <= prod[31:0];
        pend_vld <= 1'b1;
        cnt      <= CW'(MULT_CYCLES);
      end else if (go_div) begin
        pend_hi  <= rem;
        pend_lo  <= quot;
        // Divide-by-zero still burns the full latency but never commits
        pend_vld <= (md.B != 32'd0);
        cnt      <= CW'(DIV_CYCLES);
      end else if (done) begin
        cnt <= '0;
        if (pend_vld) begin
          hi_q <= pend_hi;
          lo_q <= pend_lo;
        end
      end else if (busy) begin
        cnt <= cnt - CW'(1);
      end

      if (wr_hi) hi_q <= md.A;
      if (wr_lo) lo_q <= md.A;
    end
  end

  assign md.busy  = busy;
  assign md.stall = md.useMD && (busy || (md.start && !md.req));
  assign md.HI    = hi_q;
  assign md.LO    = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed self-checking bench for md_sequencer: latency, arithmetic, gating and reset.
module tb_md_sequencer;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  md_sequencer_if md ();

  md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    md.start = 1'b0;
    md.MDop  = 3'd7;
    md.A     = 32'd0;
    md.B     = 32'd0;
    md.useMD = 1'b0;
    md.req   = 1'b0;
  endtask

  // Drives one issue cycle; the call returns just after the issuing edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    md.start = (op <= 3'd3);
    md.MDop  = op;
    md.A     = a;
    md.B     = b;
    tick();
    idle_inputs();
  endtask

  // Counts cycles with busy high, bounded so a stuck DUT still ends the run.
  task automatic count_busy(output int n);
    n = 0;
    while (md.busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset    = 1'b0;
    md.start = 1'b1;
    md.MDop  = 3'd4;
    md.A     = 32'h123;
    tick();
    tick();
    reset = 1'b1;
    idle_inputs();
    #1;
    checks++;
    if (md.busy !== 1'b0 || md.HI !== 32'd0 || md.LO !== 32'd0) begin
      errors++;
      $display("FAIL reset_state busy=%b HI=%h LO=%h required busy=0 HI=0 LO=0", md.busy, md.HI, md.LO);
    end
    md.useMD = 1'b1;
    #1;
    checks++;
    if (md.stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall got %b required 0", md.stall);
    end
    md.useMD = 1'b0;
  endtask

  task automatic test_mult();
    int n;
    issue(3'd0, 32'hFFFF_FFFD, 32'd7);
    checks++;
    if (md.busy !== 1'b1 || md.HI !== 32'd0 || md.LO !== 32'd0) begin
      errors++;
      $display("FAIL mult_issue busy=%b HI=%h LO=%h required busy=1 HI=0 LO=0", md.busy, md.HI, md.LO);
    end
    count_busy(n);
    checks++;
    if (n !== 5) begin
      errors++;
      $display("FAIL mult_latency got %0d required 5", n);
    end
    checks++;
    if (md.HI !== 32'hFFFF_FFFF || md.LO !== 32'hFFFF_FFEB) begin
      errors++;
      $display("FAIL mult_result HI=%h LO=%h required FFFFFFFF FFFFFFEB", md.HI, md.LO);
    end
  endtask

  task automatic test_div();
    int n;
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    count_busy(n);
    checks++;
    if (n !== 10) begin
      errors++;
      $display("FAIL div_latency got %0d required 10", n);
    end
    checks++;
    if (md.HI !== 32'hFFFF_FFFF || md.LO !== 32'hFFFF_FFFD) begin
      errors++;
      $display("FAIL div_signed HI=%h LO=%h required FFFFFFFF FFFFFFFD", md.HI, md.LO);
    end
    issue(3'd3, 32'd7, 32'd2);
    count_busy(n);
    checks++;
    if (n !== 10 || md.HI !== 32'd1 || md.LO !== 32'd3) begin
      errors++;
      $display("FAIL divu n=%0d HI=%h LO=%h required 10 1 3", n, md.HI, md.LO);
    end
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    count_busy(n);
    checks++;
    if (md.HI !== 32'd0 || md.LO !== 32'h8000_0000) begin
      errors++;
      $display("FAIL div_overflow HI=%h LO=%h required 0 80000000", md.HI, md.LO);
    end
  endtask

  task automatic test_div_zero();
    int n;
    issue(3'd4, 32'h11, 32'd0);
    issue(3'd5, 32'h22, 32'd0);
    checks++;
    if (md.HI !== 32'h11 || md.LO !== 32'h22 || md.busy !== 1'b0) begin
      errors++;
      $display("FAIL mthi_mtlo HI=%h LO=%h busy=%b required 11 22 0", md.HI, md.LO, md.busy);
    end
    issue(3'd3, 32'd5, 32'd0);
    count_busy(n);
    checks++;
    if (n !== 10) begin
      errors++;
      $display("FAIL divzero_latency got %0d required 10", n);
    end
    checks++;
    if (md.HI !== 32'h11 || md.LO !== 32'h22) begin
      errors++;
      $display("FAIL divzero_hold HI=%h LO=%h required 11 22", md.HI, md.LO);
    end
  endtask

  task automatic test_stall_mthi();
    int n;
    md.start = 1'b1;
    md.MDop  = 3'd1;
    md.A     = 32'hFFFF_FFFF;
    md.B     = 32'hFFFF_FFFF;
    md.useMD = 1'b1;
    #1;
    checks++;
    if (md.stall !== 1'b1) begin
      errors++;
      $display("FAIL stall_issue got %b required 1", md.stall);
    end
    tick();
    idle_inputs();
    md.useMD = 1'b1;
    n = 0;
    while (md.busy === 1'b1 && n < 40) begin
      checks++;
      if (md.stall !== 1'b1) begin
        errors++;
        $display("FAIL stall_busy cycle %0d got %b required 1", n + 1, md.stall);
      end
      n++;
      tick();
    end
    checks++;
    if (n !== 5 || md.stall !== 1'b0) begin
      errors++;
      $display("FAIL stall_release busy_cycles=%0d stall=%b required 5 0", n, md.stall);
    end
    checks++;
    if (md.HI !== 32'hFFFF_FFFE || md.LO !== 32'h0000_0001) begin
      errors++;
      $display("FAIL multu_result HI=%h LO=%h required FFFFFFFE 00000001", md.HI, md.LO);
    end
    md.MDop = 3'd4;
    md.A    = 32'h5;
    tick();
    checks++;
    if (md.HI !== 32'h5 || md.LO !== 32'h1 || md.busy !== 1'b0) begin
      errors++;
      $display("FAIL mthi_after HI=%h LO=%h busy=%b required 5 1 0", md.HI, md.LO, md.busy);
    end
    idle_inputs();
  endtask

  task automatic test_req_gate();
    md.start = 1'b1;
    md.MDop  = 3'd2;
    md.A     = 32'd9;
    md.B     = 32'd3;
    md.useMD = 1'b1;
    md.req   = 1'b1;
    #1;
    checks++;
    if (md.stall !== 1'b0) begin
      errors++;
      $display("FAIL req_stall got %b required 0", md.stall);
    end
    tick();
    md.start = 1'b0;
    md.MDop  = 3'd5;
    md.A     = 32'h99;
    tick();
    idle_inputs();
    tick();
    checks++;
    if (md.busy !== 1'b0 || md.HI !== 32'h5 || md.LO !== 32'h1) begin
      errors++;
      $display("FAIL req_gate busy=%b HI=%h LO=%h required 0 5 1", md.busy, md.HI, md.LO);
    end
  endtask

  task automatic test_busy_ignore();
    int n;
    issue(3'd0, 32'd2, 32'd3);
    md.start = 1'b1;
    md.MDop  = 3'd2;
    md.A     = 32'd100;
    md.B     = 32'd7;
    tick();
    md.start = 1'b0;
    md.MDop  = 3'd4;
    md.A     = 32'hDEAD;
    tick();
    md.start = 1'b1;
    md.MDop  = 3'd0;
    md.req   = 1'b1;
    tick();
    idle_inputs();
    count_busy(n);
    checks++;
    if (n !== 2) begin
      errors++;
      $display("FAIL busy_ignore_latency remaining=%0d required 2", n);
    end
    checks++;
    if (md.HI !== 32'd0 || md.LO !== 32'd6) begin
      errors++;
      $display("FAIL busy_ignore_result HI=%h LO=%h required 0 6", md.HI, md.LO);
    end
    tick();
    checks++;
    if (md.busy !== 1'b0 || md.HI !== 32'd0 || md.LO !== 32'd6) begin
      errors++;
      $display("FAIL busy_ignore_after busy=%b HI=%h LO=%h required 0 0 6", md.busy, md.HI, md.LO);
    end
  endtask

  task automatic test_reset_mid();
    issue(3'd4, 32'h77, 32'd0);
    issue(3'd0, 32'd7, 32'd9);
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++;
    if (md.busy !== 1'b0 || md.HI !== 32'd0 || md.LO !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid busy=%b HI=%h LO=%h required 0 0 0", md.busy, md.HI, md.LO);
    end
    repeat (8) tick();
    checks++;
    if (md.busy !== 1'b0 || md.HI !== 32'd0 || md.LO !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_later busy=%b HI=%h LO=%h required 0 0 0", md.busy, md.HI, md.LO);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    idle_inputs();
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_stall_mthi();
    test_req_gate();
    test_busy_ignore();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_sequencer.md
MD_SEQUENCER -- requirements
Module: md_sequencer

Interface
REQ-001 Parameter MULT_CYCLES, default 5, busy cycles for mult/multu.
REQ-002 Parameter DIV_CYCLES, default 10, busy cycles for div/divu.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  reset is synchronous and active-low (reset==0 at a rising edge resets).
REQ-005 start  in  1  E-stage mult/multu/div/divu issue strobe.
REQ-006 MDop  in  3  operation select: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6-7 no-op.
REQ-007 A  in  32  forwarded rs operand (E stage).
REQ-008 B  in  32  forwarded rt operand (E stage).
REQ-009 useMD  in  1  the D-stage instruction touches HI/LO (mf/mt/md class).
REQ-010 req  in  1  exception/interrupt flush; the E-stage instruction is cancelled.
REQ-011 busy  out  1  operation in progress.
REQ-012 stall  out  1  hold D stage and freeze PC/IF-ID, bubble into E.
REQ-013 HI  out  32  architectural HI register.
REQ-014 LO  out  32  architectural LO register.

Function
REQ-015 FSM states SHALL be IDLE, MUL, DIV; a down-counter cnt (4 bits min) and a pending {hi,lo} result pair SHALL be held internally.
REQ-016 In IDLE, start==1 && req==0 && MDop in {0,1} SHALL latch the product into pending, load cnt=MULT_CYCLES, enter MUL.
REQ-017 In IDLE, start==1 && req==0 && MDop in {2,3} SHALL latch quotient/remainder into pending, load cnt=DIV_CYCLES, enter DIV.
REQ-018 Start at edge t SHALL make busy 1 for cycles t+1..t+N (N = cycle parameter); HI/LO SHALL update at edge t+N; busy SHALL be 0 at t+N+1 and FSM SHALL be IDLE.
REQ-019 mult: signed 32x32 -> 64, HI=[63:32], LO=[31:0]; multu: same, unsigned.
REQ-020 div: LO=signed quotient truncated toward zero, HI=remainder with the dividend's sign; divu: unsigned quotient/remainder; A is dividend, B is divisor.
REQ-021 div/divu with B==0 SHALL still run DIV_CYCLES with busy=1 and SHALL leave HI/LO unchanged at completion.
REQ-022 div with A=0x80000000, B=0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-023 MDop==4 && req==0 in IDLE SHALL write HI=A at the same edge; MDop==5 writes LO=A; busy stays 0.
REQ-024 MDop 4/5 and the start qualification SHALL be gated by req; with req==1 no state changes.
REQ-025 start, or MDop 4/5, while busy==1 SHALL be ignored; cnt and pending SHALL not change.
REQ-026 req asserted while busy SHALL NOT abort; the committed operation completes and writes HI/LO.
REQ-027 stall SHALL equal useMD && (busy || (start && !req)), combinational, so a D-stage mf/mt/md waits until the cycle after busy falls.
REQ-028 HI/LO outputs SHALL be registers; mfhi/mflo read is combinational from them.

Reset
REQ-029 reset==0 at an edge SHALL set state=IDLE, cnt=0, busy=0, HI=0, LO=0, pending=0, overriding start and MDop.
REQ-030 Reset mid-operation SHALL discard the pending result; the next cycle has busy=0 and no HI/LO write.

Verification
REQ-031 mult A=0xFFFFFFFD, B=7 at edge t -> busy 1 for t+1..t+5; at t+5 HI=0xFFFFFFFF, LO=0xFFFFFFEB; busy 0 at t+6.
REQ-032 div A=0xFFFFFFF9 (-7), B=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=2 -> LO=3, HI=1.
REQ-033 HI=0x11, LO=0x22, divu B=0 -> busy 10 cycles, then HI=0x11, LO=0x22.
REQ-034 multu started, useMD=1 held next cycle -> stall=1 in the issue cycle and all 5 busy cycles, stall=0 after; mthi A=0x5 then sets HI=0x5 same edge.
REQ-035 start=1 with req=1 -> busy stays 0, HI/LO unchanged, stall=useMD&&0=0; mtlo with req=1 -> LO unchanged.
REQ-036 mult started, reset=0 at busy cycle 3 -> next cycle busy=0, HI=LO=0, no later write.
